// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared states, opcodes, ALU codes and mux encodings for the multicycle controller
package mc_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        ALU_WB_R = 4'd3,
        EXEC_I   = 4'd4,
        ALU_WB_I = 4'd5,
        MEM_ADDR = 4'd6,
        MEM_RD   = 4'd7,
        MEM_WR   = 4'd8,
        MEM_WB   = 4'd9,
        BRANCH   = 4'd10,
        JUMP     = 4'd11,
        TRAP     = 4'd12
    } mc_state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_SRA = 6'h03;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [3:0] ALU_AND = 4'h0;
    localparam logic [3:0] ALU_OR  = 4'h1;
    localparam logic [3:0] ALU_ADD = 4'h2;
    localparam logic [3:0] ALU_XOR = 4'h3;
    localparam logic [3:0] ALU_SLL = 4'h4;
    localparam logic [3:0] ALU_SRL = 4'h5;
    localparam logic [3:0] ALU_SUB = 4'h6;
    localparam logic [3:0] ALU_SLT = 4'h7;
    localparam logic [3:0] ALU_SRA = 4'h8;
    localparam logic [3:0] ALU_NOR = 4'hC;

    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_RS    = 2'b01;
    localparam logic [1:0] SRC_A_SHAMT = 2'b10;

    localparam logic [1:0] SRC_B_RT    = 2'b00;
    localparam logic [1:0] SRC_B_FOUR  = 2'b01;
    localparam logic [1:0] SRC_B_IMM   = 2'b10;
    localparam logic [1:0] SRC_B_BROFS = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    // States that own the memory port and therefore run the watchdog
    function automatic logic is_mem_state(input logic [3:0] s);
        return (s == FETCH) || (s == MEM_RD) || (s == MEM_WR);
    endfunction

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// rtl/mc_ctrl_fsm_if.sv - instruction/datapath/memory signal bundle between controller and datapath
interface mc_ctrl_fsm_if #(
    parameter int ALU_CTRL_W = 4
);
    logic [5:0]            opcode;
    logic [5:0]            funct;
    logic                  zero;
    logic                  mem_ready;
    logic                  mem_req;
    logic                  mem_we;
    logic                  iord;
    logic                  ir_write;
    logic                  pc_write;
    logic                  pc_write_cond;
    logic [1:0]            pc_src;
    logic [1:0]            alu_src_a;
    logic [1:0]            alu_src_b;
    logic                  ext_zero;
    logic [ALU_CTRL_W-1:0] alu_control;
    logic                  reg_write;
    logic                  reg_dst;
    logic                  mem_to_reg;
    logic                  timeout;
    logic                  illegal;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, pc_src,
               alu_src_a, alu_src_b, ext_zero, alu_control, reg_write, reg_dst,
               mem_to_reg, timeout, illegal
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, pc_src,
               alu_src_a, alu_src_b, ext_zero, alu_control, reg_write, reg_dst,
               mem_to_reg, timeout, illegal
    );
endinterface

// File: rtl/mc_alu_decode.sv
// rtl/mc_alu_decode.sv - combinational opcode/funct to ALU operation, shift select, zero-extend and validity
module mc_alu_decode
    import mc_pkg::*;
#(
    parameter int ALU_CTRL_W = 4
) (
    input  logic [5:0]            i_opcode,
    input  logic [5:0]            i_funct,
    output logic [ALU_CTRL_W-1:0] o_alu_control,
    output logic                  o_shift,
    output logic                  o_ext_zero,
    output logic                  o_valid
);
    logic [3:0] w_alu;

    // Unknown encodings fall back to ADD so the datapath sees a benign op
    always_comb begin
        w_alu      = ALU_ADD;
        o_shift    = 1'b0;
        o_ext_zero = 1'b0;
        o_valid    = 1'b1;
        case (i_opcode)
            OP_RTYPE: begin
                case (i_funct)
                    FN_AND:  w_alu = ALU_AND;
                    FN_OR:   w_alu = ALU_OR;
                    FN_NOR:  w_alu = ALU_NOR;
                    FN_XOR:  w_alu = ALU_XOR;
                    FN_SLL:  begin w_alu = ALU_SLL; o_shift = 1'b1; end
                    FN_SRL:  begin w_alu = ALU_SRL; o_shift = 1'b1; end
                    FN_SRA:  begin w_alu = ALU_SRA; o_shift = 1'b1; end
                    FN_SLT:  w_alu = ALU_SLT;
                    FN_ADD:  w_alu = ALU_ADD;
                    FN_SUB:  w_alu = ALU_SUB;
                    default: o_valid = 1'b0;
                endcase
            end
            OP_ADDI:        w_alu = ALU_ADD;
            OP_ANDI:        begin w_alu = ALU_AND; o_ext_zero = 1'b1; end
            OP_ORI:         begin w_alu = ALU_OR;  o_ext_zero = 1'b1; end
            OP_XORI:        begin w_alu = ALU_XOR; o_ext_zero = 1'b1; end
            OP_SLTI:        w_alu = ALU_SLT;
            OP_LW, OP_SW:   w_alu = ALU_ADD;
            OP_BEQ, OP_BNE: w_alu = ALU_SUB;
            OP_J:           w_alu = ALU_ADD;
            default:        o_valid = 1'b0;
        endcase
    end

    assign o_alu_control = ALU_CTRL_W'(w_alu);

endmodule

// File: rtl/mc_ctrl_fsm.sv
// rtl/mc_ctrl_fsm.sv - multicycle MIPS control FSM with memory wait states and watchdog
// Define MC_CTRL_ILLEGAL_TRAP_EN to trap unknown opcode/funct into a sticky TRAP state.
module mc_ctrl_fsm
    import mc_pkg::*;
#(
    parameter int ALU_CTRL_W  = 4,
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clk_en,
    mc_ctrl_fsm_if.master bus
);
    localparam logic [3:0] S_FETCH    = FETCH;
    localparam logic [3:0] S_DECODE   = DECODE;
    localparam logic [3:0] S_EXEC_R   = EXEC_R;
    localparam logic [3:0] S_ALU_WB_R = ALU_WB_R;
    localparam logic [3:0] S_EXEC_I   = EXEC_I;
    localparam logic [3:0] S_ALU_WB_I = ALU_WB_I;
    localparam logic [3:0] S_MEM_ADDR = MEM_ADDR;
    localparam logic [3:0] S_MEM_RD   = MEM_RD;
    localparam logic [3:0] S_MEM_WR   = MEM_WR;
    localparam logic [3:0] S_MEM_WB   = MEM_WB;
    localparam logic [3:0] S_BRANCH   = BRANCH;
    localparam logic [3:0] S_JUMP     = JUMP;
    localparam logic [3:0] S_TRAP     = TRAP;

    logic [3:0]            r_state;
    logic [3:0]            w_next;
    logic [CNT_W-1:0]      r_wait_cnt;
    logic                  r_timeout;
    logic                  r_wb_kill;
    logic                  w_illegal;
    logic                  w_in_mem;
    logic                  w_wd_fire;

    logic [ALU_CTRL_W-1:0] w_dec_alu;
    logic                  w_dec_shift;
    logic                  w_dec_ez;
    logic                  w_dec_valid;

    logic                  w_mem_req;
    logic                  w_mem_we;
    logic                  w_iord;
    logic                  w_ir_write;
    logic                  w_pc_write;
    logic                  w_pc_write_cond;
    logic [1:0]            w_pc_src;
    logic [1:0]            w_alu_src_a;
    logic [1:0]            w_alu_src_b;
    logic                  w_ext_zero;
    logic [ALU_CTRL_W-1:0] w_alu_control;
    logic                  w_reg_write;
    logic                  w_reg_dst;
    logic                  w_mem_to_reg;

    mc_alu_decode #(
        .ALU_CTRL_W (ALU_CTRL_W)
    ) u_alu_decode (
        .i_opcode      (bus.opcode),
        .i_funct       (bus.funct),
        .o_alu_control (w_dec_alu),
        .o_shift       (w_dec_shift),
        .o_ext_zero    (w_dec_ez),
        .o_valid       (w_dec_valid)
    );

    // Fires on the last permitted waiting cycle; a same-cycle mem_ready completes instead
    assign w_in_mem  = is_mem_state(r_state);
    assign w_wd_fire = (TIMEOUT_CYC > 0) && w_in_mem && !bus.mem_ready &&
                       (r_wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:    if (bus.mem_ready) w_next = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_RTYPE:                             w_next = S_EXEC_R;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_XORI,
                    OP_SLTI:                              w_next = S_EXEC_I;
                    OP_LW, OP_SW:                         w_next = S_MEM_ADDR;
                    OP_BEQ, OP_BNE:                       w_next = S_BRANCH;
                    OP_J:                                 w_next = S_JUMP;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                    default:                              w_next = S_TRAP;
`else
                    default:                              w_next = S_FETCH;
`endif
                endcase
            end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            S_EXEC_R:   w_next = w_dec_valid ? S_ALU_WB_R : S_TRAP;
`else
            S_EXEC_R:   w_next = S_ALU_WB_R;
`endif
            S_ALU_WB_R: w_next = S_FETCH;
            S_EXEC_I:   w_next = S_ALU_WB_I;
            S_ALU_WB_I: w_next = S_FETCH;
            S_MEM_ADDR: w_next = (bus.opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   if (bus.mem_ready) w_next = S_MEM_WB;
            S_MEM_WR:   if (bus.mem_ready) w_next = S_FETCH;
            S_MEM_WB:   w_next = S_FETCH;
            S_BRANCH:   w_next = S_FETCH;
            S_JUMP:     w_next = S_FETCH;
            S_TRAP:     w_next = S_TRAP;
            default:    w_next = S_FETCH;
        endcase
        if (w_wd_fire) w_next = S_FETCH;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_FETCH;
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
            r_wb_kill  <= 1'b0;
        end else if (clk_en) begin
            r_state <= w_next;
            // A fired watchdog re-enters FETCH, which counts as a fresh mem state
            if (w_wd_fire || (w_next != r_state)) begin
                r_wait_cnt <= '0;
            end else if (w_in_mem) begin
                r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            end
            if (w_wd_fire) r_timeout <= 1'b1;
            if (r_state == S_EXEC_R) r_wb_kill <= !w_dec_valid;
        end
    end

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    logic r_illegal;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_illegal <= 1'b0;
        end else if (clk_en && (w_next == S_TRAP)) begin
            r_illegal <= 1'b1;
        end
    end

    assign w_illegal = r_illegal;
`else
    assign w_illegal = 1'b0;
`endif

    always_comb begin
        w_mem_req       = 1'b0;
        w_mem_we        = 1'b0;
        w_iord          = 1'b0;
        w_ir_write      = 1'b0;
        w_pc_write      = 1'b0;
        w_pc_write_cond = 1'b0;
        w_pc_src        = PC_SRC_ALU;
        w_alu_src_a     = SRC_A_PC;
        w_alu_src_b     = SRC_B_RT;
        w_ext_zero      = 1'b0;
        w_alu_control   = ALU_CTRL_W'(ALU_AND);
        w_reg_write     = 1'b0;
        w_reg_dst       = 1'b0;
        w_mem_to_reg    = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mem_req     = 1'b1;
                w_alu_src_b   = SRC_B_FOUR;
                w_alu_control = ALU_CTRL_W'(ALU_ADD);
                w_ir_write    = bus.mem_ready && clk_en;
                w_pc_write    = bus.mem_ready && clk_en;
            end
            S_DECODE: begin
                w_alu_src_b   = SRC_B_BROFS;
                w_alu_control = ALU_CTRL_W'(ALU_ADD);
            end
            S_EXEC_R: begin
                w_alu_src_a   = w_dec_shift ? SRC_A_SHAMT : SRC_A_RS;
                w_alu_control = w_dec_alu;
            end
            S_ALU_WB_R: begin
                w_reg_write = !r_wb_kill && clk_en;
                w_reg_dst   = 1'b1;
            end
            S_EXEC_I: begin
                w_alu_src_a   = SRC_A_RS;
                w_alu_src_b   = SRC_B_IMM;
                w_alu_control = w_dec_alu;
                w_ext_zero    = w_dec_ez;
            end
            S_ALU_WB_I: w_reg_write = clk_en;
            S_MEM_ADDR: begin
                w_alu_src_a   = SRC_A_RS;
                w_alu_src_b   = SRC_B_IMM;
                w_alu_control = ALU_CTRL_W'(ALU_ADD);
            end
            S_MEM_RD: begin
                w_mem_req = 1'b1;
                w_iord    = 1'b1;
            end
            S_MEM_WR: begin
                w_mem_req = 1'b1;
                w_mem_we  = 1'b1;
                w_iord    = 1'b1;
            end
            S_MEM_WB: begin
                w_reg_write  = clk_en;
                w_mem_to_reg = 1'b1;
            end
            S_BRANCH: begin
                w_alu_src_a     = SRC_A_RS;
                w_alu_control   = ALU_CTRL_W'(ALU_SUB);
                w_pc_src        = PC_SRC_ALUOUT;
                w_pc_write_cond = clk_en && ((bus.opcode == OP_BNE) ? !bus.zero : bus.zero);
            end
            S_JUMP: begin
                w_pc_write = clk_en;
                w_pc_src   = PC_SRC_JUMP;
            end
            default: ;
        endcase
    end

    // Reset forces every output low, so mem_req drops without waiting for a clock
    assign bus.mem_req       = !rst && w_mem_req;
    assign bus.mem_we        = !rst && w_mem_we;
    assign bus.iord          = !rst && w_iord;
    assign bus.ir_write      = !rst && w_ir_write;
    assign bus.pc_write      = !rst && w_pc_write;
    assign bus.pc_write_cond = !rst && w_pc_write_cond;
    assign bus.pc_src        = rst ? 2'b00 : w_pc_src;
    assign bus.alu_src_a     = rst ? 2'b00 : w_alu_src_a;
    assign bus.alu_src_b     = rst ? 2'b00 : w_alu_src_b;
    assign bus.ext_zero      = !rst && w_ext_zero;
    assign bus.alu_control   = rst ? '0 : w_alu_control;
    assign bus.reg_write     = !rst && w_reg_write;
    assign bus.reg_dst       = !rst && w_reg_dst;
    assign bus.mem_to_reg    = !rst && w_mem_to_reg;
    assign bus.timeout       = !rst && r_timeout;
    assign bus.illegal       = !rst && w_illegal;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb/tb_mc_ctrl_fsm.sv - table-driven, scoreboarded bench for mc_ctrl_fsm (TIMEOUT_CYC=4)
module tb_mc_ctrl_fsm;

    localparam logic [3:0] A_AND = 4'h0, A_OR  = 4'h1, A_ADD = 4'h2, A_XOR = 4'h3;
    localparam logic [3:0] A_SUB = 4'h6, A_SLT = 4'h7, A_SRA = 4'h8;

    localparam logic [5:0] OPR = 6'h00, OPJ = 6'h02, OPBEQ = 6'h04, OPBNE = 6'h05;
    localparam logic [5:0] OPADDI = 6'h08, OPSLTI = 6'h0A, OPORI = 6'h0D;
    localparam logic [5:0] OPLW = 6'h23, OPSW = 6'h2B, OPBAD = 6'h3F;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic       ext_zero;
        logic [3:0] alu_control;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       timeout;
        logic       illegal;
    } out_t;

    typedef struct {
        string      name;
        logic       rst;
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        logic       rdy;
        logic       en;
        out_t       exp;
    } vec_t;

    typedef struct {
        string name;
        out_t  exp;
    } sb_t;

    logic   clk;
    logic   rst;
    logic   clk_en;
    logic   exp_to;
    logic   exp_il;
    int     checks;
    int     failures;
    vec_t   vt[$];
    sb_t    sb[$];

    mc_ctrl_fsm_if #(.ALU_CTRL_W(4)) bus ();

    mc_ctrl_fsm #(
        .ALU_CTRL_W  (4),
        .TIMEOUT_CYC (4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .clk_en (clk_en),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got running required done");
        $fatal(1);
    end

    function automatic out_t o_base();
        out_t o;
        o = '0;
        o.timeout = exp_to;
        o.illegal = exp_il;
        return o;
    endfunction

    function automatic out_t o_fetch(logic w);
        out_t o = o_base();
        o.mem_req = 1'b1; o.alu_src_b = 2'b01; o.alu_control = A_ADD;
        o.ir_write = w; o.pc_write = w;
        return o;
    endfunction

    function automatic out_t o_decode();
        out_t o = o_base();
        o.alu_src_b = 2'b11; o.alu_control = A_ADD;
        return o;
    endfunction

    function automatic out_t o_exec_r(logic [3:0] a, logic sh);
        out_t o = o_base();
        o.alu_src_a = sh ? 2'b10 : 2'b01; o.alu_control = a;
        return o;
    endfunction

    function automatic out_t o_wb_r(logic w);
        out_t o = o_base();
        o.reg_write = w; o.reg_dst = 1'b1;
        return o;
    endfunction

    function automatic out_t o_exec_i(logic [3:0] a, logic ez);
        out_t o = o_base();
        o.alu_src_a = 2'b01; o.alu_src_b = 2'b10; o.alu_control = a; o.ext_zero = ez;
        return o;
    endfunction

    function automatic out_t o_wb_i(logic w);
        out_t o = o_base();
        o.reg_write = w;
        return o;
    endfunction

    function automatic out_t o_addr();
        out_t o = o_base();
        o.alu_src_a = 2'b01; o.alu_src_b = 2'b10; o.alu_control = A_ADD;
        return o;
    endfunction

    function automatic out_t o_mem(logic we);
        out_t o = o_base();
        o.mem_req = 1'b1; o.iord = 1'b1; o.mem_we = we;
        return o;
    endfunction

    function automatic out_t o_mwb(logic w);
        out_t o = o_base();
        o.reg_write = w; o.mem_to_reg = 1'b1;
        return o;
    endfunction

    function automatic out_t o_br(logic p);
        out_t o = o_base();
        o.alu_src_a = 2'b01; o.alu_control = A_SUB; o.pc_src = 2'b01; o.pc_write_cond = p;
        return o;
    endfunction

    function automatic out_t o_jmp(logic w);
        out_t o = o_base();
        o.pc_write = w; o.pc_src = 2'b10;
        return o;
    endfunction

    function automatic vec_t mk(string nm, logic r, logic [5:0] op, logic [5:0] fn,
                                logic z, logic rdy, logic en, out_t e);
        vec_t v;
        v.name = nm; v.rst = r; v.op = op; v.fn = fn;
        v.z = z; v.rdy = rdy; v.en = en; v.exp = e;
        return v;
    endfunction

    function automatic out_t act();
        out_t o;
        o.mem_req = bus.mem_req;         o.mem_we = bus.mem_we;
        o.iord = bus.iord;               o.ir_write = bus.ir_write;
        o.pc_write = bus.pc_write;       o.pc_write_cond = bus.pc_write_cond;
        o.pc_src = bus.pc_src;           o.alu_src_a = bus.alu_src_a;
        o.alu_src_b = bus.alu_src_b;     o.ext_zero = bus.ext_zero;
        o.alu_control = bus.alu_control; o.reg_write = bus.reg_write;
        o.reg_dst = bus.reg_dst;         o.mem_to_reg = bus.mem_to_reg;
        o.timeout = bus.timeout;         o.illegal = bus.illegal;
        return o;
    endfunction

    task automatic apply(vec_t v);
        sb_t s;
        rst = v.rst; clk_en = v.en;
        bus.opcode = v.op; bus.funct = v.fn; bus.zero = v.z; bus.mem_ready = v.rdy;
        s.name = v.name; s.exp = v.exp;
        sb.push_back(s);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            sb_t  s;
            out_t a;
            s = sb.pop_front();
            a = act();
            checks++;
            if (a !== s.exp) begin
                failures++;
                $display("FAIL %s: got %h required %h", s.name, a, s.exp);
            end
        end
    end

    initial begin
        checks = 0; failures = 0; exp_to = 1'b0; exp_il = 1'b0;
        rst = 1'b1; clk_en = 1'b1;
        bus.opcode = '0; bus.funct = '0; bus.zero = 1'b0; bus.mem_ready = 1'b0;

        vt.push_back(mk("add.fetch",  0, OPR, 6'h20, 0, 1, 1, o_fetch(1)));
        vt.push_back(mk("add.decode", 0, OPR, 6'h20, 0, 0, 1, o_decode()));
        vt.push_back(mk("add.exec",   0, OPR, 6'h20, 0, 0, 1, o_exec_r(A_ADD, 0)));
        vt.push_back(mk("add.wb",     0, OPR, 6'h20, 0, 0, 1, o_wb_r(1)));
        vt.push_back(mk("sra.fetch",  0, OPR, 6'h03, 0, 1, 1, o_fetch(1)));
        vt.push_back(mk("sra.decode", 0, OPR, 6'h03, 0, 0, 1, o_decode()));
        vt.push_back(mk("sra.exec",   0, OPR, 6'h03, 0, 0, 1, o_exec_r(A_SRA, 1)));
        vt.push_back(mk("sra.wb",     0, OPR, 6'h03, 0, 0, 1, o_wb_r(1)));
        vt.push_back(mk("j.fetch_en0",0, OPJ, 6'h00, 0, 1, 0, o_fetch(0)));
        vt.push_back(mk("j.fetch",    0, OPJ, 6'h00, 0, 1, 1, o_fetch(1)));
        vt.push_back(mk("j.decode",   0, OPJ, 6'h00, 0, 0, 1, o_decode()));
        vt.push_back(mk("j.jump",     0, OPJ, 6'h00, 0, 0, 1, o_jmp(1)));
        vt.push_back(mk("lw.fetch",   0, OPLW, 6'h00, 0, 1, 1, o_fetch(1)));
        vt.push_back(mk("lw.decode",  0, OPLW, 6'h00, 0, 0, 1, o_decode()));
        vt.push_back(mk("lw.addr",    0, OPLW, 6'h00, 0, 0, 1, o_addr()));
        for (int i = 0; i < 3; i++)
            vt.push_back(mk("lw.rd_wait", 0, OPLW, 6'h00, 0, 0, 1, o_mem(0)));
        vt.push_back(mk("lw.rd_limit",0, OPLW, 6'h00, 0, 1, 1, o_mem(0)));
        vt.push_back(mk("lw.wb",      0, OPLW, 6'h00, 0, 0, 1, o_mwb(1)));
        vt.push_back(mk("sw.fetch",   0, OPSW, 6'h00, 0, 1, 1, o_fetch(1)));
        vt.push_back(mk("sw.decode",  0, OPSW, 6'h00, 0, 0, 1, o_decode()));
        vt.push_back(mk("sw.addr",    0, OPSW, 6'h00, 0, 0, 1, o_addr()));
        vt.push_back(mk("sw.wr_wait", 0, OPSW, 6'h00, 0, 0, 1, o_mem(1)));
        vt.push_back(mk("sw.wr_done", 0, OPSW, 6'h00, 0, 1, 1, o_mem(1)));
        vt.push_back(mk("beq0.fetch", 0, OPBEQ, 6'h00, 0, 1, 1, o_fetch(1)));
        vt.push_back(mk("beq0.decode",0, OPBEQ, 6'h00, 0, 0, 1, o_decode()));
        vt.push_back(mk("beq0.branch",0, OPBEQ, 6'h00, 0, 0, 1, o_br(0)));
        vt.push_back(mk("beq1.fetch", 0, OPBEQ, 6'h00, 1, 1, 1, o_fetch(1)));
        vt.push_back(mk("beq1.decode",0, OPBEQ, 6'h00, 1, 0, 1, o_decode()));
        vt.push_back(mk("beq1.branch",0, OPBEQ, 6'h00, 1, 0, 1, o_br(1)));
        vt.push_back(mk("bne1.fetch", 0, OPBNE, 6'h00, 1, 1, 1, o_fetch(1)));
        vt.push_back(mk("bne1.decode",0, OPBNE, 6'h00, 1, 0, 1, o_decode()));
        vt.push_back(mk("bne1.branch",0, OPBNE, 6'h00, 1, 0, 1, o_br(0)));
        vt.push_back(mk("ori.fetch",  0, OPORI, 6'h00, 0, 1, 1, o_fetch(1)));
        vt.push_back(mk("ori.decode", 0, OPORI, 6'h00, 0, 0, 1, o_decode()));
        vt.push_back(mk("ori.exec_en0",0, OPORI, 6'h00, 0, 0, 0, o_exec_i(A_OR, 1)));
        vt.push_back(mk("ori.exec_en0",0, OPORI, 6'h00, 0, 0, 0, o_exec_i(A_OR, 1)));
        vt.push_back(mk("ori.exec",   0, OPORI, 6'h00, 0, 0, 1, o_exec_i(A_OR, 1)));
        vt.push_back(mk("ori.wb",     0, OPORI, 6'h00, 0, 0, 1, o_wb_i(1)));
        vt.push_back(mk("slti.fetch", 0, OPSLTI, 6'h00, 0, 1, 1, o_fetch(1)));
        vt.push_back(mk("slti.decode",0, OPSLTI, 6'h00, 0, 0, 1, o_decode()));
        vt.push_back(mk("slti.exec",  0, OPSLTI, 6'h00, 0, 0, 1, o_exec_i(A_SLT, 0)));
        vt.push_back(mk("slti.wb",    0, OPSLTI, 6'h00, 0, 0, 1, o_wb_i(1)));
        vt.push_back(mk("addi.fetch", 0, OPADDI, 6'h00, 0, 1, 1, o_fetch(1)));
        vt.push_back(mk("addi.decode",0, OPADDI, 6'h00, 0, 0, 1, o_decode()));
        vt.push_back(mk("addi.exec",  0, OPADDI, 6'h00, 0, 0, 1, o_exec_i(A_ADD, 0)));
        vt.push_back(mk("addi.wb_en0",0, OPADDI, 6'h00, 0, 0, 0, o_wb_i(0)));
        vt.push_back(mk("addi.wb",    0, OPADDI, 6'h00, 0, 0, 1, o_wb_i(1)));

        @(posedge clk);
        #1;
        apply(mk("reset.outputs", 1, OPR, 6'h20, 0, 1, 1, o_base()));
        foreach (vt[i]) apply(vt[i]);

        // Watchdog in FETCH: four waiting cycles, then a fetch with the sticky flag set
        for (int i = 0; i < 4; i++)
            apply(mk("to.fetch_wait", 0, OPJ, 6'h00, 0, 0, 1, o_fetch(0)));
        exp_to = 1'b1;
        apply(mk("to.fetch_ok",  0, OPJ, 6'h00, 0, 1, 1, o_fetch(1)));
        apply(mk("to.decode",    0, OPJ, 6'h00, 0, 0, 1, o_decode()));
        apply(mk("to.jump",      0, OPJ, 6'h00, 0, 0, 1, o_jmp(1)));
        apply(mk("to.sticky",    0, OPJ, 6'h00, 0, 0, 1, o_fetch(0)));

        // Reset in the middle of a pending fetch request
        exp_to = 1'b0;
        apply(mk("rst.mid_fetch", 1, OPJ, 6'h00, 0, 0, 1, o_base()));
        apply(mk("rst.release",   0, OPJ, 6'h00, 0, 0, 1, o_fetch(0)));

        apply(mk("bad.fetch",     0, OPBAD, 6'h00, 0, 1, 1, o_fetch(1)));
        apply(mk("bad.decode",    0, OPBAD, 6'h00, 0, 0, 1, o_decode()));
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        exp_il = 1'b1;
        for (int i = 0; i < 3; i++)
            apply(mk("bad.trap", 0, OPBAD, 6'h00, 0, 1, 1, o_base()));
        exp_il = 1'b0;
        apply(mk("bad.reset",     1, OPBAD, 6'h00, 0, 0, 1, o_base()));
        apply(mk("bad.refetch",   0, OPJ, 6'h00, 0, 0, 1, o_fetch(0)));
`else
        apply(mk("bad.nop_fetch", 0, OPR, 6'h3F, 0, 1, 1, o_fetch(1)));
        apply(mk("badfn.decode",  0, OPR, 6'h3F, 0, 0, 1, o_decode()));
        apply(mk("badfn.exec",    0, OPR, 6'h3F, 0, 0, 1, o_exec_r(A_ADD, 0)));
        apply(mk("badfn.wb",      0, OPR, 6'h3F, 0, 0, 1, o_wb_r(0)));
        apply(mk("badfn.refetch", 0, OPR, 6'h20, 0, 0, 1, o_fetch(0)));
`endif

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Parametrised multicycle MIPS control FSM; the next-generation controller after the R-type-only 3-state unit.
- Sequences fetch/decode/execute/memory/writeback for R-type, ALU-immediate, lw/sw, beq/bne and j.
- Adds memory ready/request handshake with wait states and a watchdog timeout.
- Sits between instruction register (opcode/funct) and datapath muxes/enables, plus the unified memory port.

Parameters:
- ALU_CTRL_W, 4, width of alu_control; encodings from shared package.
- TIMEOUT_CYC, 64, max cycles waiting for mem_ready before abort; 0 disables the watchdog.
- CNT_W, $clog2(TIMEOUT_CYC+1), wait-counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- clk_en  in  1  state/counter advance enable.
- opcode  in  6  IR[31:26].
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag, used by branches.
- mem_ready  in  1  memory completes current access this cycle.
- mem_req  out  1  memory access request.
- mem_we  out  1  write (sw).
- iord  out  1  0=PC address, 1=ALUOut address.
- ir_write  out  1  load IR.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  conditional PC load (branch taken).
- pc_src  out  2  00 ALU, 01 ALUOut, 10 jump target.
- alu_src_a  out  2  00 PC, 01 rs, 10 shamt.
- alu_src_b  out  2  00 rt, 01 const 4, 10 ext imm, 11 sext imm<<2.
- ext_zero  out  1  zero-extend imm (andi/ori/xori).
- alu_control  out  ALU_CTRL_W  ALU op.
- reg_write  out  1  RF write.
- reg_dst  out  1  1=rd, 0=rt.
- mem_to_reg  out  1  1=MDR to RF.
- timeout  out  1  sticky; memory watchdog fired.
- illegal  out  1  sticky; unsupported opcode/funct (macro only).

Behaviour:
- Reset: state=FETCH, wait counter=0, timeout=0, illegal=0.
- While rst is asserted, all outputs are 0, including mem_req.
- Outputs are combinational from state (Moore) except where marked "&mem_ready".
- All state/counter updates are gated by clk_en. Write enables are qualified by clk_en.
- FETCH: mem_req=1, iord=0, A=00, B=01, ADD, pc_src=00.
  - ir_write and pc_write are asserted only when mem_ready&clk_en; that cycle goes to DECODE.
  - Otherwise stay in FETCH and increment the counter.
- DECODE: A=00, B=11, ADD (branch target precompute). Next state by opcode:
  - 0x00 → EXEC_R.
  - 0x08/0x0C/0x0D/0x0E/0x0A → EXEC_I.
  - 0x23/0x2B → MEM_ADDR.
  - 0x04/0x05 → BRANCH.
  - 0x02 → JUMP.
  - Other → FETCH (no writes).
- EXEC_R: funct map (AND,OR,NOR,XOR,SLL,SRL,SRA,SLT,ADD,SUB).
  - Shifts use A=10, B=00; others A=01, B=00.
  - Unknown funct: ADD with writeback suppressed. → ALU_WB_R.
- ALU_WB_R: reg_write=1, reg_dst=1 (suppressed for unknown funct). → FETCH.
- EXEC_I: A=01, B=10; addi ADD, andi AND (ext_zero), ori OR (ext_zero), xori XOR (ext_zero), slti SLT. → ALU_WB_I.
- ALU_WB_I: reg_write=1, reg_dst=0. → FETCH.
- MEM_ADDR: A=01, B=10, ADD. → MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: mem_req=1, iord=1. Leaves to MEM_WB on mem_ready.
- MEM_WR: mem_req=1, mem_we=1, iord=1. Leaves to FETCH on mem_ready.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1. → FETCH.
- BRANCH: A=01, B=00, SUB, pc_src=01. pc_write_cond=(zero for beq, !zero for bne). → FETCH.
- JUMP: pc_write=1, pc_src=10. → FETCH.
- Wait counter: cleared on entry to any mem state, incremented each waiting cycle.
  - If TIMEOUT_CYC>0 and counter reaches TIMEOUT_CYC without mem_ready: set timeout, drop mem_req, return to FETCH with no ir/pc/reg writes.
  - mem_ready arriving in the same cycle as the limit wins (access completes).
- Sticky flags clear only on rst.
- Reset mid-access: immediate return to FETCH; mem_req deasserts asynchronously.

Optional Feature:
- Macro: MC_CTRL_ILLEGAL_TRAP_EN.
- Defined: unknown opcode in DECODE or unknown funct in EXEC_R goes to TRAP.
  - TRAP sets illegal=1 and holds all enables at 0 until rst.
- Undefined: unknown opcode/funct behave as NOP as described above; illegal is tied to 0.

Decomposition:
- Shared package mc_pkg holds:
  - State enum (FETCH, DECODE, EXEC_R, ALU_WB_R, EXEC_I, ALU_WB_I, MEM_ADDR, MEM_RD, MEM_WR, MEM_WB, BRANCH, JUMP, TRAP).
  - Opcode/funct constants.
  - ALU_* codes.
  - ALU source and pc_src mux encodings.
- One sub-module, mc_alu_decode: combinational funct/opcode → alu_control, shift-select, ext_zero, valid flag.
- FSM plus watchdog stays in mc_ctrl_fsm.

Test Plan:
- add (op 0x00, funct 0x20), mem_ready high → FETCH, DECODE, EXEC_R, ALU_WB_R. reg_write=1, reg_dst=1 in cycle 4; ALU_ADD in cycle 3.
- lw with mem_ready low 3 cycles in MEM_RD → mem_req held 4 cycles, iord=1. MEM_WB follows with mem_to_reg=1; total 5+3 cycles.
- beq with zero=0, then zero=1 → pc_write_cond=0 then 1 in BRANCH; alu_control=SUB; pc_src=01.
- TIMEOUT_CYC=4, mem_ready held low in FETCH → after 4 wait cycles timeout=1, no ir_write, state FETCH. Next mem_ready fetch succeeds and timeout stays 1.
- clk_en=0 for 2 cycles during EXEC_I (ori) → state held, no reg_write. Resumes with ext_zero=1, ALU_OR.
- Opcode 0x3F: with macro, illegal=1 and stall until rst; without macro, return to FETCH with no writes.
